// File: rtl/event_capture_fifo.sv
// Event capture FIFO: stores {timestamp, event_data} on each enabled event pulse,
// drained by a read strobe. Define EVENT_CAPTURE_DROP_CNT_EN to add a saturating drop counter.
module event_capture_fifo #(
  parameter int DEPTH    = 16,
  parameter int TS_WIDTH = 32,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   capture_enable,
  input  logic                   event_in,
  input  logic [31:0]            event_data,
  input  logic                   rd_en,
  output logic [32+TS_WIDTH-1:0] rd_data,
  output logic                   rd_valid,
  output logic [AW:0]            fifo_count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow
`ifdef EVENT_CAPTURE_DROP_CNT_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  localparam int DW = 32 + TS_WIDTH;

  logic                en_q;
  logic                clr;
  logic [TS_WIDTH-1:0] ts;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [DW-1:0]       mem [DEPTH];

  logic push_req;
  logic pop;
  logic push;
  logic drop;

  assign empty = (fifo_count == '0);
  assign full  = (fifo_count == (AW+1)'(DEPTH));

  // A pop while full frees a slot in the same cycle, so a simultaneous push still fits.
  assign push_req = event_in & capture_enable;
  assign pop      = rd_en & ~empty;
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q       <= 1'b0;
      clr        <= 1'b0;
      ts         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      en_q <= capture_enable;
      clr  <= capture_enable & ~en_q;
      if (clr) begin
        ts         <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        overflow   <= 1'b0;
        rd_valid   <= 1'b0;
      end else begin
        if (capture_enable) ts <= ts + TS_WIDTH'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr  <= rd_ptr + AW'(1);
          rd_data <= mem[rd_ptr];
        end
        rd_valid <= pop;
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
          2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
          default: fifo_count <= fifo_count;
        endcase
        if (drop) overflow <= 1'b1;
      end
    end
  end

  // NOTE: the storage array is deliberately left without reset; entries are only
  // ever read after being written, and a reset here would block RAM inference.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= {ts, event_data};
  end

`ifdef EVENT_CAPTURE_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (clr) begin
      drop_count <= '0;
    end else if (drop && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule
